key_store: RTL and testbench
============================

KEY_STORE -- requirements
Module: key_store

Interface
REQ-001 The block SHALL expose parameter KEY_WIDTH, default 32, giving the width of the stored key, keyBuffer and keyPass.
REQ-002 The block SHALL expose parameter CNT_WIDTH, default 8, giving the width of keyCount.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 keyEnable  input  1  block enable; when 0 all state holds.
REQ-007 readKey  input  1  operation select: 1 = read stored key to keyPass, 0 = load keyBuffer into the stored key.
REQ-008 keyBuffer  input  KEY_WIDTH  key value to be loaded.
REQ-009 keyPass  output  KEY_WIDTH  registered copy of the stored key, updated only by a read.
REQ-010 keyValid  output  1  high once at least one key has been loaded since reset.
REQ-011 keyCount  output  CNT_WIDTH  saturating count of loads since reset.

Function
REQ-012 The block SHALL hold an internal KEY_WIDTH key register; all outputs SHALL be registered.
REQ-013 Load: on a rising clk with rst=0, keyEnable=1, readKey=0, the key register SHALL take keyBuffer, keyValid SHALL become 1, keyCount SHALL increment by 1, and keyPass SHALL hold.
REQ-014 Read: on a rising clk with rst=0, keyEnable=1, readKey=1, keyPass SHALL take the key register value as held before that edge; key register, keyValid and keyCount SHALL hold.
REQ-015 Latency: a key loaded at edge N SHALL appear on keyPass at the first read edge M>N; keyPass SHALL be valid one cycle after the read edge.
REQ-016 Load and read are mutually exclusive per cycle (selected by readKey); back-to-back load then read on consecutive edges SHALL return the newly loaded key.
REQ-017 Consecutive loads SHALL overwrite; only the last loaded value SHALL be returned by a later read.
REQ-018 A read before any load SHALL drive keyPass to all zeros, with keyValid remaining 0.
REQ-019 keyEnable=0 SHALL hold all state and outputs regardless of readKey and keyBuffer.
REQ-020 keyCount SHALL saturate at 2^CNT_WIDTH-1 and not wrap; further loads still update the key register.
REQ-021 Loading an all-zero keyBuffer SHALL be a normal load (keyValid=1, keyCount increments).
REQ-022 Outputs SHALL never depend combinationally on inputs.

Reset
REQ-023 On a rising clk with rst=1, key register, keyPass and keyCount SHALL clear to 0 and keyValid SHALL clear to 0.
REQ-024 rst SHALL take priority over keyEnable/readKey in the same cycle; a load or read coincident with rst SHALL be discarded.
REQ-025 Reset mid-operation SHALL discard the stored key; a subsequent read without a new load SHALL return 0.
REQ-026 Before the first reset edge, output values are unspecified; benches SHALL apply rst for at least one clk edge.

Verification
REQ-027 Reset, then keyEnable=1 readKey=1 (read with no load) -> keyPass=0, keyValid=0, keyCount=0.
REQ-028 Load keyBuffer=4, next edge read -> keyPass=4 after the read edge, keyValid=1, keyCount=1; keyPass stays 0 during the load cycle.
REQ-029 Load 16, load 32, read (keyBuffer=64 driven during read) -> keyPass=32, key register unchanged at 32, keyCount=2.
REQ-030 keyEnable=0 with readKey=0 keyBuffer=0xDEADBEEF, then enabled read -> keyPass returns the previously stored key, keyCount unchanged.
REQ-031 Load 8, assert rst coincident with a read, then read -> keyPass=0 at both reads, keyValid=0.
REQ-032 Load 255 distinct values then 2 more (CNT_WIDTH=8) -> keyCount=255, read returns the last loaded value.

Source files
------------

// File: rtl/key_store.sv
// key_store: single-entry key register with registered read-out port.
//
// Ports:
//   clk        in   sole clock, all state changes on its rising edge
//   rst        in   synchronous active-high reset, overrides every operation
//   keyEnable  in   block enable; when low, all state holds
//   readKey    in   1 = copy the stored key to keyPass, 0 = load keyBuffer
//   keyBuffer  in   [KEY_WIDTH] key value to load
//   keyPass    out  [KEY_WIDTH] registered copy of the stored key, updated only by a read
//   keyValid   out  high once at least one key has been loaded since reset
//   keyCount   out  [CNT_WIDTH] saturating count of loads since reset
module key_store #(
  parameter int unsigned KEY_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 keyEnable,
  input  logic                 readKey,
  input  logic [KEY_WIDTH-1:0] keyBuffer,
  output logic [KEY_WIDTH-1:0] keyPass,
  output logic                 keyValid,
  output logic [CNT_WIDTH-1:0] keyCount
);

  logic [KEY_WIDTH-1:0] key_q,   key_d;
  logic [KEY_WIDTH-1:0] pass_q,  pass_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    key_d   = key_q;
    pass_d  = pass_q;
    valid_d = valid_q;
    count_d = count_q;
    if (keyEnable) begin
      if (readKey) begin
        // Read returns the key as held before this edge.
        pass_d = key_q;
      end else begin
        key_d   = keyBuffer;
        valid_d = 1'b1;
        // Saturate at all-ones; the key itself still updates.
        if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      pass_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      key_q   <= key_d;
      pass_q  <= pass_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign keyPass  = pass_q;
  assign keyValid = valid_q;
  assign keyCount = count_q;

endmodule

// File: tb/tb_key_store.sv
module tb_key_store;

  localparam int unsigned KW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          keyEnable = 1'b0;
  logic          readKey = 1'b0;
  logic [KW-1:0] keyBuffer = '0;
  logic [KW-1:0] keyPass;
  logic          keyValid;
  logic [CW-1:0] keyCount;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: what the block must hold, in plain terms.
  logic [KW-1:0] m_key;
  logic [KW-1:0] m_pass;
  logic          m_valid;
  int unsigned   m_loads;

  key_store #(.KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .keyEnable (keyEnable),
    .readKey   (readKey),
    .keyBuffer (keyBuffer),
    .keyPass   (keyPass),
    .keyValid  (keyValid),
    .keyCount  (keyCount)
  );

  always #5 clk = ~clk;

  task automatic check_all(input string tag);
    logic [CW-1:0] exp_cnt;
    exp_cnt = CW'((m_loads > CMAX) ? CMAX : m_loads);
    n_asserts++;
    assert (keyPass === m_pass) else begin
      n_fails++;
      $error("FAIL %s.keyPass observed=%h expected=%h", tag, keyPass, m_pass);
    end
    n_asserts++;
    assert (keyValid === m_valid) else begin
      n_fails++;
      $error("FAIL %s.keyValid observed=%b expected=%b", tag, keyValid, m_valid);
    end
    n_asserts++;
    assert (keyCount === exp_cnt) else begin
      n_fails++;
      $error("FAIL %s.keyCount observed=%0d expected=%0d", tag, keyCount, exp_cnt);
    end
  endtask

  // Apply one cycle of inputs, let one rising edge pass, update model, check.
  task automatic step(input logic r, input logic en, input logic rd,
                      input logic [KW-1:0] kb, input string tag);
    rst = r; keyEnable = en; readKey = rd; keyBuffer = kb;
    @(posedge clk);
    #1;
    if (r) begin
      m_key = '0; m_pass = '0; m_valid = 1'b0; m_loads = 0;
    end else if (en) begin
      if (rd) m_pass = m_key;
      else begin
        m_key = kb; m_valid = 1'b1; m_loads++;
      end
    end
    check_all(tag);
  endtask

  initial begin
    m_key = '0; m_pass = '0; m_valid = 1'b0; m_loads = 0;

    // Reset and read with no prior load
    step(1, 0, 0, '0, "reset");
    step(1, 1, 1, 32'h1234_5678, "reset_hold");
    step(0, 1, 1, '0, "read_no_load");

    // Load 4 then read on the next edge
    step(0, 1, 0, 32'd4, "load4");
    step(0, 1, 1, '0, "read4");

    // Overwrite: 16, 32, then read while 64 is on keyBuffer
    step(1, 0, 0, '0, "reset2");
    step(0, 1, 0, 32'd16, "load16");
    step(0, 1, 0, 32'd32, "load32");
    step(0, 1, 1, 32'd64, "read32");
    step(0, 1, 1, 32'd64, "read32_again");

    // Disabled cycles hold everything
    step(0, 0, 0, 32'hDEAD_BEEF, "disabled_load");
    step(0, 0, 1, 32'hDEAD_BEEF, "disabled_read");
    step(0, 1, 1, '0, "read_after_disable");

    // Reset coincident with a read discards the key
    step(0, 1, 0, 32'd8, "load8");
    step(1, 1, 1, '0, "rst_with_read");
    step(0, 1, 1, '0, "read_after_rst");

    // All-zero load is an ordinary load
    step(0, 1, 0, 32'hFFFF_FFFF, "load_ones");
    step(0, 1, 0, '0, "load_zero");
    step(0, 1, 1, '0, "read_zero");

    // Saturation: 255 distinct loads, then two more
    step(1, 0, 0, '0, "reset_sat");
    for (int i = 1; i <= 257; i++) begin
      step(0, 1, 0, KW'(32'hA000_0000 + i), "sat_load");
    end
    step(0, 1, 1, '0, "sat_read");

    // Randomized traffic against the model
    step(1, 0, 0, '0, "reset_rand");
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1, $urandom(), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
